// File: rtl/stage4_mem.sv
// MEM stage of the five-stage MIPS pipeline: data-memory access over a req/ack
// port with a bounded wait, branch resolution, and the MEM/WB pipeline register.
module stage4_mem #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc4,
  input  logic [31:0] alurslt,
  input  logic        zero,
  input  logic [31:0] data2,
  input  logic [4:0]  wrreg,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic        regwrite,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] baddr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] rdata_out,
  output logic [31:0] alurslt_out,
  output logic [4:0]  wrreg_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        bus_err,
  output logic        state_dbg
);

  // Handshake: dm_req rises on the edge leaving IDLE and stays high (with
  // dm_addr/dm_wdata/dm_we stable) until the edge on which dm_ack is sampled
  // high or the wait budget runs out; dm_ack outside ACCESS has no effect.
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] counter;
  logic [4:0]       wrreg_q;
  logic             memtoreg_q;
  logic             regwrite_q;
  logic             mem_op;
  logic             timeout;

  assign mem_op    = memread | memwrite;
  assign timeout   = (state == ACCESS) && (counter == CNT_W'(TIMEOUT - 1));
  assign pcsrc     = branch & zero & ~stall;
  assign baddr     = pc4;
  assign state_dbg = state;

  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = mem_op;
    else               stall = ~dm_ack & ~timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter      <= '0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      bus_err      <= 1'b0;
      wrreg_q      <= '0;
      memtoreg_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      rdata_out    <= '0;
      alurslt_out  <= '0;
      wrreg_out    <= '0;
      memtoreg_out <= 1'b0;
      regwrite_out <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            // A store wins when both memread and memwrite are set.
            dm_addr      <= alurslt;
            dm_wdata     <= data2;
            dm_we        <= memwrite;
            wrreg_q      <= wrreg;
            memtoreg_q   <= memtoreg;
            regwrite_q   <= regwrite;
            dm_req       <= 1'b1;
            counter      <= '0;
            memtoreg_out <= 1'b0;
            regwrite_out <= 1'b0;
            state        <= ACCESS;
          end else begin
            alurslt_out  <= alurslt;
            wrreg_out    <= wrreg;
            memtoreg_out <= memtoreg;
            regwrite_out <= regwrite;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            if (!dm_we) rdata_out <= dm_rdata;
            alurslt_out  <= dm_addr;
            wrreg_out    <= wrreg_q;
            memtoreg_out <= memtoreg_q;
            regwrite_out <= regwrite_q;
            dm_req       <= 1'b0;
            state        <= IDLE;
          end else if (timeout) begin
            // Abandoned access retires as a bubble with an error pulse.
            bus_err      <= 1'b1;
            memtoreg_out <= 1'b0;
            regwrite_out <= 1'b0;
            dm_req       <= 1'b0;
            state        <= IDLE;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
